// File: rtl/seq_unsigned_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// with start/done handshake, busy indication and divide-by-zero flag.
module seq_unsigned_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int RW = WIDTH + 1;

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [RW-1:0]    rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [RW:0]      shifted;
   logic             ge;
   logic [RW-1:0]    step_rem;
   logic [WIDTH-1:0] step_quot;

   // The dividend register shifts out its MSB each step and collects
   // quotient bits at the bottom, so it holds the quotient after WIDTH steps.
   always_comb begin
      shifted   = {rem_q, dvd_q[WIDTH-1]};
      ge        = shifted >= {2'b00, dvs_q};
      step_rem  = RW'(ge ? (shifted - {2'b00, dvs_q}) : shifted);
      step_quot = {dvd_q[WIDTH-2:0], ge};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;

      case (state_q)
         CALC: begin
            rem_d = step_rem;
            dvd_d = step_quot;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = FINISH;
               quot_d  = step_quot;
               remo_d  = step_rem[WIDTH-1:0];
               dbz_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            if (start) begin
               if (divisor != '0) begin
                  dvd_d   = dividend;
                  dvs_d   = divisor;
                  rem_d   = '0;
                  cnt_d   = CW'(WIDTH);
                  state_d = CALC;
               end else begin
                  quot_d  = '1;
                  remo_d  = '1;
                  dbz_d   = 1'b1;
                  state_d = FINISH;
               end
            end
         end
      endcase

      busy_d = (state_d == CALC);
      done_d = (state_d == FINISH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = remo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Directed checks of seq_unsigned_divider at WIDTH=8 plus an exhaustive
// back-to-back sweep at WIDTH=4.
module tb_seq_unsigned_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] dvd8 = '0, dvs8 = '0;
   logic       busy8, done8, dbz8;
   logic [7:0] quot8, rem8;

   logic       start4 = 1'b0;
   logic [3:0] dvd4 = '0, dvs4 = '0;
   logic       busy4, done4, dbz4;
   logic [3:0] quot4, rem4;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   seq_unsigned_divider #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
      .busy(busy8), .done(done8), .quotient(quot8), .remainder(rem8),
      .div_by_zero(dbz8)
   );

   seq_unsigned_divider #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .dividend(dvd4), .divisor(dvs4),
      .busy(busy4), .done(done4), .quotient(quot4), .remainder(rem4),
      .div_by_zero(dbz4)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
      int         lat;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Start one WIDTH=8 operation and wait (bounded) for its done pulse.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat,
                       output logic busy_ok);
      start8 = 1'b1;
      dvd8   = a;
      dvs8   = b;
      tick();
      start8  = 1'b0;
      lat     = 1;
      busy_ok = 1'b1;
      while (done8 !== 1'b1 && lat < 40) begin
         if (busy8 !== (b != 8'd0)) busy_ok = 1'b0;
         tick();
         lat++;
      end
      if (busy8 !== 1'b0) busy_ok = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      logic       bok;
      logic       early;
      logic       any_done;
      logic [7:0] qsave;

      vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,   z: 1'b0, lat: 9};
      vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0, lat: 9};
      vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   z: 1'b0, lat: 9};
      vecs[3] = '{a: 8'd77,  b: 8'd0,   q: 8'hFF,  r: 8'hFF,  z: 1'b1, lat: 1};
      vecs[4] = '{a: 8'd100, b: 8'd10,  q: 8'd10,  r: 8'd0,   z: 1'b0, lat: 9};
      vecs[5] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   z: 1'b0, lat: 9};
      vecs[6] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0, lat: 9};
      vecs[7] = '{a: 8'd250, b: 8'd16,  q: 8'd15,  r: 8'd10,  z: 1'b0, lat: 9};
      vecs[8] = '{a: 8'd254, b: 8'd255, q: 8'd0,   r: 8'd254, z: 1'b0, lat: 9};

      // Reset state
      tick();
      tick();
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_quot", quot8, 0);
      chk("rst_rem", rem8, 0);
      chk("rst_dbz", dbz8, 0);
      rst = 1'b0;
      tick();

      // Table-driven single operations
      foreach (vecs[i]) begin
         run8(vecs[i].a, vecs[i].b, lat, bok);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_quot", i), quot8, vecs[i].q);
         chk($sformatf("vec%0d_rem", i), rem8, vecs[i].r);
         chk($sformatf("vec%0d_dbz", i), dbz8, vecs[i].z);
         chk($sformatf("vec%0d_busy_profile", i), bok, 1);
         qsave = quot8;
         tick();
         chk($sformatf("vec%0d_done_single", i), done8, 0);
         chk($sformatf("vec%0d_quot_hold", i), quot8, qsave);
      end

      // Start during CALC is ignored; start in the done cycle runs back-to-back
      cyc    = 0;
      early  = 1'b0;
      start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd3;
      tick();
      start8 = 1'b0;
      while (cyc < 4) begin
         if (done8) early = 1'b1;
         tick();
      end
      start8 = 1'b1; dvd8 = 8'd9; dvs8 = 8'd9;
      chk("ignore_busy_c4", busy8, 1);
      tick();
      start8 = 1'b0;
      while (cyc < 9) begin
         if (done8) early = 1'b1;
         tick();
      end
      chk("ignore_no_early_done", early, 0);
      chk("ignore_done_c9", done8, 1);
      chk("ignore_quot", quot8, 33);
      chk("ignore_rem", rem8, 1);
      early  = 1'b0;
      start8 = 1'b1; dvd8 = 8'd9; dvs8 = 8'd9;
      tick();
      start8 = 1'b0;
      while (cyc < 18) begin
         if (done8) early = 1'b1;
         tick();
      end
      chk("b2b_no_early_done", early, 0);
      chk("b2b_done_c18", done8, 1);
      chk("b2b_quot", quot8, 1);
      chk("b2b_rem", rem8, 0);
      tick();

      // Reset mid-CALC aborts without a done pulse
      run8(8'd200, 8'd7, lat, bok);
      tick();
      cyc    = 0;
      start8 = 1'b1; dvd8 = 8'd200; dvs8 = 8'd7;
      tick();
      start8 = 1'b0;
      while (cyc < 5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", busy8, 0);
      chk("abort_done", done8, 0);
      chk("abort_quot", quot8, 0);
      chk("abort_rem", rem8, 0);
      chk("abort_dbz", dbz8, 0);
      any_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done8 || busy8) any_done = 1'b1;
         tick();
      end
      chk("abort_no_done", any_done, 0);
      run8(8'd200, 8'd7, lat, bok);
      chk("after_abort_latency", lat, 9);
      chk("after_abort_quot", quot8, 28);
      chk("after_abort_rem", rem8, 4);
      tick();

      // start coincident with rst is ignored
      rst = 1'b1;
      start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd5;
      tick();
      rst = 1'b0;
      start8 = 1'b0;
      tick();
      chk("rst_start_busy", busy8, 0);
      chk("rst_start_done", done8, 0);

      // Exhaustive WIDTH=4 sweep, start held high for back-to-back operation
      start4 = 1'b1;
      for (int k = 0; k < 256; k++) begin
         int         n;
         logic [3:0] av, bv, eq, er;
         av   = 4'(k / 16);
         bv   = 4'(k % 16);
         dvd4 = av;
         dvs4 = bv;
         eq   = (bv == 4'd0) ? 4'hF : av / bv;
         er   = (bv == 4'd0) ? 4'hF : av % bv;
         n    = 0;
         do begin
            tick();
            n++;
         end while (done4 !== 1'b1 && n < 20);
         chk($sformatf("sweep_%0d_%0d_spacing", av, bv), n, (bv == 4'd0) ? 1 : 5);
         chk($sformatf("sweep_%0d_%0d_quot", av, bv), quot4, eq);
         chk($sformatf("sweep_%0d_%0d_rem", av, bv), rem4, er);
         chk($sformatf("sweep_%0d_%0d_dbz", av, bv), dbz4, bv == 4'd0);
         chk($sformatf("sweep_%0d_%0d_busy_at_done", av, bv), busy4, 0);
      end
      start4 = 1'b0;
      tick();
      tick();
      chk("sweep_idle_after", busy4 | done4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
